cdc_fifo_wr_arbiter: RTL and testbench
======================================

Name: cdc_fifo_wr_arbiter

Overview:
- Write-side burst arbiter that shares one asynchronous FIFO (occupancy-reporting variant) among N_REQ requesters in the clk_wr domain.
- Grants whole bursts round-robin, and only when the FIFO's free space covers the entire burst. A granted burst therefore never stalls on full.
- Each FIFO word is tagged with the source id and a last flag, so the read domain can de-multiplex packets.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WIDTH, 8, payload width per beat.
- SLOTS, 8, depth of the attached FIFO (power of 2, >=2).
- MAX_BURST, 4, maximum beats per burst (1..SLOTS).
- ID_W, $clog2(N_REQ), derived: source-id width.
- LEN_W, $clog2(MAX_BURST+1), derived: burst-length field width.
- FIFO_W, WIDTH+ID_W+1, derived: FIFO word width.

Ports:
- clk_wr  in  1  write-domain clock.
- arst_wr  in  1  reset, asynchronous, active-high.
- req_valid_i  in  N_REQ  per-requester beat valid.
- req_len_i  in  N_REQ*LEN_W  per-requester burst length; sampled with the first beat only.
- req_data_i  in  N_REQ*WIDTH  per-requester beat payload.
- req_ready_o  out  N_REQ  per-requester beat accept.
- fifo_wr_en_o  out  1  FIFO write enable.
- fifo_wr_data_o  out  FIFO_W  {last, id, payload}.
- fifo_wr_full_i  in  1  FIFO full flag.
- fifo_ocup_i  in  $clog2(SLOTS)+1  FIFO occupancy, write-domain view.
- busy_o  out  1  burst in progress.
- gnt_id_o  out  ID_W  id of the current or last granted requester.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (arst_wr high, asynchronous):
  - State goes to IDLE; rr pointer = 0; beat counter = 0.
  - req_ready_o = 0, fifo_wr_en_o = 0, busy_o = 0, gnt_id_o = 0, err_o = 0.
  - Reset mid-burst abandons the burst immediately. Beats already written stay in the FIFO; the FIFO has its own reset.
- FSM states: IDLE, BURST.
- IDLE:
  - Winner = first requester with req_valid_i set, scanning from the rr pointer upward with wrap.
  - Strict round-robin: if the winner's burst does not fit, the arbiter waits. It does not skip to a later requester, so long bursts are never starved.
  - free = SLOTS - fifo_ocup_i, computed at $clog2(SLOTS)+1 bits, never negative.
  - eff_len = req_len_i of the winner. If len is 0 or > MAX_BURST: eff_len = 1 and err_o is set.
  - If a winner exists and free >= eff_len: register gnt_id_o = winner, counter = eff_len, busy_o = 1, go to BURST.
  - req_ready_o is 0 throughout IDLE.
- BURST:
  - req_ready_o[gnt] = ~fifo_wr_full_i; all other ready bits are 0.
  - Beat accepted when req_valid_i[gnt] and req_ready_o[gnt]. On acceptance: fifo_wr_en_o = 1 in the same cycle (combinational), counter decrements.
  - fifo_wr_data_o = {counter==1, gnt, req_data_i[gnt]}.
  - A requester dropping valid mid-burst inserts bubbles; the grant is held.
  - On acceptance with counter==1: go to IDLE, rr pointer = gnt+1 (mod N_REQ), busy_o = 0 on the next cycle.
- fifo_wr_full_i seen high in BURST is a reservation violation: err_o is set and the write is suppressed that cycle. err_o clears only on reset.
- Latency:
  - First beat is accepted no earlier than 1 cycle after the grant decision.
  - One IDLE bubble cycle between consecutive bursts.
  - Peak throughput inside a burst is 1 beat/cycle.
- fifo_ocup_i reflects a write on the next cycle, so IDLE after a burst sees the updated occupancy. A lagging read pointer only makes free pessimistic, which is safe.
- Elaboration-time assertions: SLOTS is a power of 2; 1 <= MAX_BURST <= SLOTS; N_REQ >= 2.

Test Plan:
- Reset, then req0 with len=3 and data 0xA1,0xA2,0xA3, FIFO empty -> 3 writes on consecutive cycles; words {0,0,A1},{0,0,A2},{1,0,A3}; busy_o falls after the third beat; err_o = 0.
- All 4 requesters valid with len=1, FIFO empty -> grant order 0,1,2,3,0; one bubble cycle between writes; gnt_id_o follows that order.
- SLOTS=8, fifo_ocup_i=6, req1 with len=4 and req2 with len=1, rr pointer=1 -> no grant (req2 is not granted); raise free to 4 (ocup=4) -> req1 gets 4 beats, then req2.
- Grant req3 with len=4; drop req_valid_i[3] for 2 cycles after beat 2 -> no writes during the gap; beats 3 and 4 are written afterwards; last flag only on beat 4.
- req0 with len=0 -> one beat written with last=1; err_o = 1 and stays set. Separately, force fifo_wr_full_i mid-burst -> write suppressed, err_o = 1.
- Assert arst_wr during beat 2 of a len=4 burst -> all outputs at reset values within the reset cycle; after release, rr pointer = 0 and a fresh burst from req0 is granted normally.

Source files
------------

// File: rtl/cdc_fifo_wr_arbiter_if.sv
// cdc_fifo_wr_arbiter_if: requester beat bus and FIFO write port shared by the burst arbiter.
// master is the arbiter's view; slave is the requesters/FIFO environment.
interface cdc_fifo_wr_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int SLOTS     = 8,
    parameter int MAX_BURST = 4
);
    localparam int ID_W   = $clog2(N_REQ);
    localparam int LEN_W  = $clog2(MAX_BURST + 1);
    localparam int FIFO_W = WIDTH + ID_W + 1;
    localparam int OCW    = $clog2(SLOTS) + 1;

    logic [N_REQ-1:0]       req_valid_i;
    logic [N_REQ*LEN_W-1:0] req_len_i;
    logic [N_REQ*WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic                   fifo_wr_en_o;
    logic [FIFO_W-1:0]      fifo_wr_data_o;
    logic                   fifo_wr_full_i;
    logic [OCW-1:0]         fifo_ocup_i;

    modport master (
        input  req_valid_i, req_len_i, req_data_i, fifo_wr_full_i, fifo_ocup_i,
        output req_ready_o, fifo_wr_en_o, fifo_wr_data_o
    );
    modport slave (
        output req_valid_i, req_len_i, req_data_i, fifo_wr_full_i, fifo_ocup_i,
        input  req_ready_o, fifo_wr_en_o, fifo_wr_data_o
    );
endinterface

// File: rtl/cdc_fifo_wr_arbiter.sv
// cdc_fifo_wr_arbiter: round-robin whole-burst arbiter in front of an async FIFO write port.
// A burst is granted only when the reported free space covers it, so it never stalls on full.
module cdc_fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int SLOTS     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk_wr,
    input  logic                       arst_wr,
    cdc_fifo_wr_arbiter_if.master      bus,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   gnt_id_o,
    output logic                       err_o
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int LEN_W = $clog2(MAX_BURST + 1);
    localparam int OCW   = $clog2(SLOTS) + 1;

    if (N_REQ < 2) begin : g_bad_nreq
        $error("N_REQ must be >= 2");
    end
    if (SLOTS < 2 || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
        $error("SLOTS must be a power of 2 >= 2");
    end
    if (MAX_BURST < 1 || MAX_BURST > SLOTS) begin : g_bad_burst
        $error("MAX_BURST must be in 1..SLOTS");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t             r_state, w_next;
    logic [ID_W-1:0]    r_rr, r_gnt, w_win;
    logic [LEN_W-1:0]   r_cnt, w_len, w_eff;
    logic [OCW-1:0]     w_free;
    logic [N_REQ-1:0]   w_ready;
    logic               r_err, w_found, w_bad, w_grant, w_acc, w_last;

    function automatic logic [ID_W-1:0] wrap(input int v);
        return ID_W'(v >= N_REQ ? v - N_REQ : v);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && bus.req_valid_i[wrap(int'(r_rr) + k)]) begin
                w_found = 1'b1;
                w_win   = wrap(int'(r_rr) + k);
            end
        end
    end

    // Out-of-range lengths still move one beat so the requester cannot wedge the arbiter.
    assign w_len   = bus.req_len_i[int'(w_win)*LEN_W +: LEN_W];
    assign w_bad   = (w_len == '0) || (int'(w_len) > MAX_BURST);
    assign w_eff   = w_bad ? LEN_W'(1) : w_len;
    assign w_free  = (int'(bus.fifo_ocup_i) >= SLOTS) ? '0 : OCW'(SLOTS - int'(bus.fifo_ocup_i));
    assign w_grant = (r_state == IDLE) && w_found && (int'(w_free) >= int'(w_eff));
    assign w_last  = (r_cnt == LEN_W'(1));
    assign w_acc   = (r_state == BURST) && bus.req_valid_i[r_gnt] && !bus.fifo_wr_full_i;

    always_comb begin
        w_next  = r_state;
        w_ready = '0;
        if (r_state == IDLE && w_grant)
            w_next = BURST;
        if (r_state == BURST) begin
            w_ready[r_gnt] = ~bus.fifo_wr_full_i;
            if (w_acc && w_last)
                w_next = IDLE;
        end
    end

    assign bus.req_ready_o    = w_ready;
    assign bus.fifo_wr_en_o   = w_acc;
    assign bus.fifo_wr_data_o = {w_last, r_gnt, bus.req_data_i[int'(r_gnt)*WIDTH +: WIDTH]};
    assign busy_o             = (r_state == BURST);
    assign gnt_id_o           = r_gnt;
    assign err_o              = r_err;

    always_ff @(posedge clk_wr or posedge arst_wr) begin
        if (arst_wr) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt <= w_win;
                r_cnt <= w_eff;
            end else if (w_acc) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end
            if (w_acc && w_last)
                r_rr <= wrap(int'(r_gnt) + 1);
            // Full inside a burst means the free-space reservation was violated.
            if ((w_grant && w_bad) || (r_state == BURST && bus.fifo_wr_full_i))
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// tb_cdc_fifo_wr_arbiter: scoreboard bench; expected FIFO words are queued with the stimulus
// and popped as the arbiter writes them.
module tb_cdc_fifo_wr_arbiter;
    localparam int N = 4;

    logic       clk_wr  = 1'b0;
    logic       arst_wr = 1'b1;
    logic       busy_o, err_o;
    logic [1:0] gnt_id_o;

    int          n_tests = 0, n_fail = 0, cyc = 0, n_wr = 0;
    logic [10:0] exp_q[$];
    logic [10:0] ew;
    int          wcyc[$];
    int          bq[N][$];
    int          bi[N], hold[N], gap_at[N], gap_len[N];
    logic [N-1:0] acc = '0;

    always #5 clk_wr = ~clk_wr;

    cdc_fifo_wr_arbiter_if #(.N_REQ(4), .WIDTH(8), .SLOTS(8), .MAX_BURST(4)) bus ();

    cdc_fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .SLOTS(8), .MAX_BURST(4)) dut (
        .clk_wr   (clk_wr),
        .arst_wr  (arst_wr),
        .bus      (bus.master),
        .busy_o   (busy_o),
        .gnt_id_o (gnt_id_o),
        .err_o    (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic add(input int i, input int len, input int beats, input int d0);
        bq[i].push_back(d0 * 65536 + beats * 256 + len);
    endtask

    task automatic push(input logic l, input logic [1:0] id, input logic [7:0] d);
        exp_q.push_back({l, id, d});
    endtask

    function automatic int pend();
        int s = 0;
        for (int i = 0; i < N; i++) s += bq[i].size();
        return s;
    endfunction

    // Monitor: scoreboard compare on every write, acceptance capture for the requester model.
    always @(negedge clk_wr) begin
        cyc++;
        acc = bus.req_valid_i & bus.req_ready_o;
        if (bus.fifo_wr_en_o) begin
            n_wr++;
            wcyc.push_back(cyc);
            if (exp_q.size() == 0) check("sb_nonempty_on_wr", exp_q.size(), 1);
            else begin
                ew = exp_q.pop_front();
                check("wr_word", bus.fifo_wr_data_o, ew);
                check("wr_gnt", gnt_id_o, ew[9:8]);
            end
        end
    end

    task automatic drive();
        logic [3:0]  v = '0;
        logic [11:0] l = '0;
        logic [31:0] d = '0;
        int e;
        for (int i = 0; i < N; i++) begin
            if (arst_wr) begin bi[i] = 0; hold[i] = 0; end
            if (hold[i] > 0) hold[i]--;
            if (acc[i] && bq[i].size() > 0) begin
                bi[i]++;
                e = bq[i][0];
                if (bi[i] == ((e >> 8) & 255)) begin
                    void'(bq[i].pop_front());
                    bi[i] = 0;
                end else if (bi[i] == gap_at[i]) hold[i] = gap_len[i];
            end
            if (bq[i].size() > 0 && hold[i] == 0) begin
                e = bq[i][0];
                v[i] = 1'b1;
                l[i*3 +: 3] = 3'(e & 7);
                d[i*8 +: 8] = 8'(((e >> 16) & 255) + bi[i]);
            end
        end
        bus.req_valid_i = v;
        bus.req_len_i   = l;
        bus.req_data_i  = d;
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_len_i   = '0;
        bus.req_data_i  = '0;
        forever begin
            @(posedge clk_wr);
            #1;
            drive();
        end
    end

    task automatic rst_chk(input string tag);
        check({tag, "_ready"}, bus.req_ready_o, 0);
        check({tag, "_wr_en"}, bus.fifo_wr_en_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_gnt"}, gnt_id_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    task automatic do_reset();
        check("sb_left", exp_q.size(), 0);
        exp_q.delete();
        arst_wr = 1'b1;
        #1;
        rst_chk("rst");
        for (int i = 0; i < N; i++) bq[i].delete();
        repeat (2) @(posedge clk_wr);
        #2;
        arst_wr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        bit done;
        do begin
            @(posedge clk_wr);
            #2;
            k++;
            done = exp_q.size() == 0 && pend() == 0 && !busy_o;
        end while (!done && k < budget);
        check("idle_timeout", done, 1);
    endtask

    task automatic wait_wr(input int target, input int budget);
        int k = 0;
        while (n_wr < target && k < budget) begin
            @(posedge clk_wr);
            #2;
            k++;
        end
        check("wr_timeout", n_wr >= target, 1);
    endtask

    initial begin
        int base;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < N; i++) begin gap_at[i] = -1; gap_len[i] = 0; end
        bus.fifo_wr_full_i = 1'b0;
        bus.fifo_ocup_i    = '0;
        do_reset();

        // single len=3 burst, back-to-back beats
        wcyc.delete();
        add(0, 3, 3, 'hA1);
        push(0, 0, 8'hA1); push(0, 0, 8'hA2); push(1, 0, 8'hA3);
        wait_idle(40);
        check("t1_span", wcyc.size() == 3 ? wcyc[2] - wcyc[0] : -1, 2);
        check("t1_busy", busy_o, 0);
        check("t1_err", err_o, 0);

        // all requesters, len=1: round robin with one bubble between bursts
        do_reset();
        wcyc.delete();
        add(0, 1, 1, 'h10); add(1, 1, 1, 'h20); add(2, 1, 1, 'h30); add(3, 1, 1, 'h40);
        add(0, 1, 1, 'h11);
        push(1, 0, 8'h10); push(1, 1, 8'h20); push(1, 2, 8'h30); push(1, 3, 8'h40); push(1, 0, 8'h11);
        wait_idle(60);
        for (int k = 0; k < 4; k++)
            check("t2_gap", wcyc.size() == 5 ? wcyc[k+1] - wcyc[k] : -1, 2);

        // strict round robin: req1 waits for space, req2 is not skipped ahead
        bus.fifo_ocup_i = 4'd6;
        base = n_wr;
        add(1, 4, 4, 'h50); add(2, 1, 1, 'h60);
        push(0, 1, 8'h50); push(0, 1, 8'h51); push(0, 1, 8'h52); push(1, 1, 8'h53); push(1, 2, 8'h60);
        repeat (6) @(posedge clk_wr);
        #2;
        check("t3_nowrite", n_wr - base, 0);
        check("t3_busy", busy_o, 0);
        bus.fifo_ocup_i = 4'd4;
        wait_idle(60);
        bus.fifo_ocup_i = '0;

        // valid gap of two cycles after beat 2; grant held
        wcyc.delete();
        gap_at[3] = 2; gap_len[3] = 2;
        add(3, 4, 4, 'h70);
        push(0, 3, 8'h70); push(0, 3, 8'h71); push(0, 3, 8'h72); push(1, 3, 8'h73);
        wait_idle(60);
        gap_at[3] = -1;
        check("t4_b12", wcyc.size() == 4 ? wcyc[1] - wcyc[0] : -1, 1);
        check("t4_gap", wcyc.size() == 4 ? wcyc[2] - wcyc[1] : -1, 3);
        check("t4_b34", wcyc.size() == 4 ? wcyc[3] - wcyc[2] : -1, 1);

        // len=0 becomes one last beat and a sticky error
        add(0, 0, 1, 'h80);
        push(1, 0, 8'h80);
        wait_idle(40);
        check("t5_err", err_o, 1);
        repeat (3) @(posedge clk_wr);
        #2;
        check("t5_err_sticky", err_o, 1);

        // full during a burst suppresses the write and flags an error
        do_reset();
        base = n_wr;
        add(0, 3, 3, 'h90);
        push(0, 0, 8'h90); push(0, 0, 8'h91); push(1, 0, 8'h92);
        wait_wr(base + 1, 40);
        bus.fifo_wr_full_i = 1'b1;
        #1;
        check("t5b_wr_en", bus.fifo_wr_en_o, 0);
        check("t5b_ready", bus.req_ready_o, 0);
        @(posedge clk_wr);
        #2;
        check("t5b_err", err_o, 1);
        bus.fifo_wr_full_i = 1'b0;
        wait_idle(40);
        check("t5b_count", n_wr - base, 3);

        // reset mid-burst, then rr must restart at 0
        do_reset();
        add(0, 1, 1, 'hA0);
        push(1, 0, 8'hA0);
        wait_idle(40);
        base = n_wr;
        add(2, 4, 4, 'hB0);
        push(0, 2, 8'hB0);
        wait_wr(base + 1, 40);
        check("t6_gnt_pre", gnt_id_o, 2);
        do_reset();
        add(1, 1, 1, 'hE0); add(0, 1, 1, 'hD0);
        push(1, 0, 8'hD0); push(1, 1, 8'hE0);
        wait_idle(40);
        check("t6_err", err_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
